// File: rtl/br_pkg.sv
// Shared encodings for the EX-stage branch resolver: branch ops, FSM states,
// and the link-register indices that mark a JALR as a return.
package br_pkg;

  localparam int BR_OP_W  = 4;
  localparam int SH_CNT_W = 4;

  typedef enum logic [BR_OP_W-1:0] {
    OP_NONE = 4'd0,
    OP_BEQ  = 4'd1,
    OP_BNE  = 4'd2,
    OP_BLT  = 4'd3,
    OP_BGE  = 4'd4,
    OP_BLTU = 4'd5,
    OP_BGEU = 4'd6,
    OP_JAL  = 4'd7,
    OP_JALR = 4'd8
  } br_op_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SHADOW = 1'b1
  } br_state_e;

  localparam logic [4:0] RA_IDX = 5'd1;
  localparam logic [4:0] T0_IDX = 5'd5;

endpackage

// File: rtl/br_compare.sv
// Branch condition evaluator: decides whether the op in EX is taken.
module br_compare
  import br_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [BR_OP_W-1:0] op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               taken
);

  always_comb begin
    // NOTE: taken gets a default before the case so unlisted ops (9..15)
    // cannot leave it unassigned and infer a latch.
    taken = 1'b0;
    case (op)
      OP_BEQ:           taken = (a == b);
      OP_BNE:           taken = (a != b);
      OP_BLT:           taken = ($signed(a) <  $signed(b));
      OP_BGE:           taken = ($signed(a) >= $signed(b));
      OP_BLTU:          taken = (a <  b);
      OP_BGEU:          taken = (a >= b);
      OP_JAL, OP_JALR:  taken = 1'b1;
      default:          taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// EX-stage branch resolution: computes the real next PC, flags mispredictions,
// squashes a fixed shadow of wrong-path slots and keeps branch statistics.
module branch_resolver
  import br_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int SHADOW_DEPTH = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CACHE_READY,
  input  logic                  CACHE_READY_DATA,
  input  logic                  EX_VALID,
  input  logic [ADDR_WIDTH-1:0] EX_PC,
  input  logic [ADDR_WIDTH-1:0] EX_PRD_ADDR,
  input  logic [BR_OP_W-1:0]    EX_BR_OP,
  input  logic [4:0]            EX_RS1_ADDR,
  input  logic [4:0]            EX_RD_ADDR,
  input  logic [ADDR_WIDTH-1:0] RS1_DATA,
  input  logic [ADDR_WIDTH-1:0] RS2_DATA,
  input  logic [ADDR_WIDTH-1:0] IMM,
  output logic [ADDR_WIDTH-1:0] RES_PC,
  output logic                  BRANCH,
  output logic                  BRANCH_TAKEN,
  output logic [ADDR_WIDTH-1:0] BRANCH_ADDR,
  output logic                  PREDICTED,
  output logic                  FLUSH,
  output logic                  RETURN,
  output logic [ADDR_WIDTH-1:0] RETURN_ADDR,
  output logic                  MISPREDICT,
  output logic [31:0]           BRANCH_COUNT,
  output logic [31:0]           MISS_COUNT
);

  logic                  accept;
  logic                  taken;
  logic                  is_jalr;
  logic                  is_ctrl;
  logic                  is_ret;
  logic                  pred_ok;
  logic [ADDR_WIDTH-1:0] target_raw;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] seq_pc;
  logic [ADDR_WIDTH-1:0] next_pc;

  br_state_e             state_q, state_d;
  logic [SH_CNT_W-1:0]   cnt_q, cnt_d;

  logic branch_d, taken_d, predicted_d, flush_d, return_d, mispredict_d;
  logic branch_inc, miss_inc;

  assign accept = CACHE_READY & CACHE_READY_DATA;

  br_compare #(.WIDTH(ADDR_WIDTH)) u_compare (
    .op    (EX_BR_OP),
    .a     (RS1_DATA),
    .b     (RS2_DATA),
    .taken (taken)
  );

  assign is_jalr    = (EX_BR_OP == OP_JALR);
  assign is_ctrl    = (EX_BR_OP >= OP_BEQ) && (EX_BR_OP <= OP_JALR);
  assign target_raw = (is_jalr ? RS1_DATA : EX_PC) + IMM;
  assign target     = is_jalr ? {target_raw[ADDR_WIDTH-1:1], 1'b0} : target_raw;
  assign seq_pc     = EX_PC + ADDR_WIDTH'(4);
  assign next_pc    = taken ? target : seq_pc;
  // A NONE op still compares against PC+4 so a stale predictor alias is caught.
  assign pred_ok    = (EX_PRD_ADDR == next_pc);
  assign is_ret     = is_jalr && (EX_RD_ADDR == 5'd0) &&
                      ((EX_RS1_ADDR == RA_IDX) || (EX_RS1_ADDR == T0_IDX));

  // Next-state and next-output values, assuming this cycle is accepted.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    branch_d     = 1'b0;
    taken_d      = 1'b0;
    predicted_d  = 1'b1;
    flush_d      = 1'b0;
    return_d     = 1'b0;
    mispredict_d = 1'b0;
    branch_inc   = 1'b0;
    miss_inc     = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (EX_VALID) begin
          branch_d     = is_ctrl;
          taken_d      = taken;
          predicted_d  = pred_ok;
          return_d     = is_ret;
          mispredict_d = !pred_ok;
          branch_inc   = is_ctrl;
          miss_inc     = !pred_ok;
          if (!pred_ok) begin
            state_d = ST_SHADOW;
            cnt_d   = SH_CNT_W'(SHADOW_DEPTH);
          end
        end
      end
      ST_SHADOW: begin
        flush_d = EX_VALID;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q <= 1) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: reset is synchronous and checked before accept, so it wins even
    // during a stall; all state uses non-blocking assignments.
    if (!RST) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      RES_PC       <= '0;
      BRANCH       <= 1'b0;
      BRANCH_TAKEN <= 1'b0;
      BRANCH_ADDR  <= '0;
      PREDICTED    <= 1'b1;
      FLUSH        <= 1'b0;
      RETURN       <= 1'b0;
      RETURN_ADDR  <= '0;
      MISPREDICT   <= 1'b0;
      BRANCH_COUNT <= '0;
      MISS_COUNT   <= '0;
    end else if (accept) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      RES_PC       <= EX_PC;
      BRANCH       <= branch_d;
      BRANCH_TAKEN <= taken_d;
      BRANCH_ADDR  <= target;
      PREDICTED    <= predicted_d;
      FLUSH        <= flush_d;
      RETURN       <= return_d;
      RETURN_ADDR  <= target;
      MISPREDICT   <= mispredict_d;
      if (branch_inc) BRANCH_COUNT <= BRANCH_COUNT + 32'd1;
      if (miss_inc)   MISS_COUNT   <= MISS_COUNT + 32'd1;
    end
  end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

EX-stage branch resolution unit: the producer side of the branch predictor's update/correction interface. Each accepted cycle it evaluates the instruction in EX (condition, target, return detection), compares the real next PC with the address fetch predicted, and drives registered resolution outputs to the predictor and the pipeline. After a misprediction it marks a fixed window of wrong-path slots as flushed, and it keeps branch and misprediction statistics.

## Interface
- ADDR_WIDTH, 32, PC/target/operand width
- SHADOW_DEPTH, 2, accepted slots squashed after a misprediction (1..15)

- CLK  in  1  clock
- RST  in  1  synchronous reset, active-low (0 = reset)
- CACHE_READY  in  1  pipeline advance qualifier
- CACHE_READY_DATA  in  1  pipeline advance qualifier; accept = CACHE_READY & CACHE_READY_DATA
- EX_VALID  in  1  EX slot holds an instruction
- EX_PC  in  ADDR_WIDTH  PC of EX instruction
- EX_PRD_ADDR  in  ADDR_WIDTH  next-fetch address predicted for this instruction
- EX_BR_OP  in  4  branch op (package encoding)
- EX_RS1_ADDR  in  5  rs1 index
- EX_RD_ADDR  in  5  rd index
- RS1_DATA, RS2_DATA  in  ADDR_WIDTH  forwarded operands
- IMM  in  ADDR_WIDTH  sign-extended immediate
- RES_PC  out  ADDR_WIDTH  PC of resolved instruction (predictor EX_PC)
- BRANCH  out  1  resolved non-squashed control-transfer instruction
- BRANCH_TAKEN  out  1  resolved taken
- BRANCH_ADDR  out  ADDR_WIDTH  taken target
- PREDICTED  out  1  prediction correct (1) or needs correction (0)
- FLUSH  out  1  resolved slot is wrong-path
- RETURN  out  1  resolved instruction is a return
- RETURN_ADDR  out  ADDR_WIDTH  return target
- MISPREDICT  out  1  kill younger stages
- BRANCH_COUNT  out  32  resolved non-squashed branches/jumps
- MISS_COUNT  out  32  mispredictions

## Operation
- Op encoding: 0 NONE, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 JAL, 8 JALR; 9–15 are treated as NONE.
- Condition: EQ/NE on full equality; LT/GE signed; LTU/GEU unsigned. JAL/JALR are always taken.
- Target: JALR = (RS1_DATA + IMM) with bit 0 cleared; all other ops = EX_PC + IMM. All sums wrap modulo 2^ADDR_WIDTH.
- Next PC: taken ? target : EX_PC + 4. PREDICTED = (EX_PRD_ADDR == next PC).
  - A NONE op whose EX_PRD_ADDR ≠ EX_PC + 4 gives PREDICTED=0, BRANCH_TAKEN=0, BRANCH=0.
- RETURN = JALR & EX_RD_ADDR==0 & EX_RS1_ADDR ∈ {1,5}. RETURN_ADDR = target.
- FSM RUN / SHADOW with a 4-bit counter; it advances only on accept.
  - RUN, valid, PREDICTED=0 → MISPREDICT=1, MISS_COUNT+1, go to SHADOW with counter = SHADOW_DEPTH.
  - SHADOW: every accepted slot (valid or not) gives FLUSH=EX_VALID, BRANCH=0, BRANCH_TAKEN=0, PREDICTED=1, RETURN=0, MISPREDICT=0, no counter increments. Counter decrements; go to RUN when it reaches 0 (the cycle after the last shadow slot).
- Invalid slot in RUN: BRANCH=0, BRANCH_TAKEN=0, PREDICTED=1, FLUSH=0, RETURN=0, MISPREDICT=0.
- BRANCH_COUNT increments on valid ops 1–8 in RUN. Both counters wrap at 2^32.

## Timing
- All outputs are registered. They reflect the EX instruction accepted at edge N from edge N onward and hold until the next accept.
- When not accepted, every output, the FSM and the counters hold. The one-cycle MISPREDICT pulse stretches across the stall.
- Reset (RST=0 at an edge): all outputs 0 except PREDICTED=1. FSM goes to RUN, counter to 0. This applies mid-SHADOW and regardless of accept.
- Reset has priority over accept in the same cycle.
- A misprediction inside SHADOW cannot occur: PREDICTED is forced to 1.

## Structure
- Package br_pkg: op encodings, BR_OP_W=4, FSM state encoding, return register indices 1 and 5.
- Sub-module br_compare: purely combinational. Takes op, RS1_DATA, RS2_DATA and gives taken. Everything else lives in branch_resolver.

## Test plan
- Reset: RST=0 → PREDICTED=1, all other outputs 0, counters 0. Holding RST=0 while accepting keeps them there.
- BEQ taken: PC=0x100, RS1=RS2=5, IMM=0x20, PRD=0x120 → BRANCH=1, TAKEN=1, BRANCH_ADDR=0x120, PREDICTED=1, MISPREDICT=0, BRANCH_COUNT=1.
- BLT signed mispredict: RS1=0xFFFFFFFF, RS2=1, PC=0x200, IMM=0x40, PRD=0x204 → TAKEN=1, PREDICTED=0, MISPREDICT=1. With SHADOW_DEPTH=2, the next 2 accepted valid slots give FLUSH=1, BRANCH=0. The third slot resolves normally. MISS_COUNT=1.
- Return: JALR rs1=1, rd=0, RS1=0x3001, IMM=0 → RETURN=1, RETURN_ADDR=0x3000, TAKEN=1. The same op with rd=1 → RETURN=0.
- Stall mid-shadow: drop CACHE_READY for 3 cycles after the mispredict → outputs and counter frozen, shadow still covers exactly 2 accepted slots.
- Alias fix: NONE op, PC=0x400, PRD=0x800 → PREDICTED=0, BRANCH=0, TAKEN=0, MISPREDICT=1.
